// File: rtl/regfile_dump.sv
// Register-file dump engine: walks the read port across all register addresses
// and streams each (addr, data) pair out on a valid/ready interface.
module regfile_dump #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SKIP_X0  = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_rs_addr,
  input  logic [DATA_W-1:0] i_rs_data,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic [ADDR_W-1:0] o_dump_addr,
  output logic [DATA_W-1:0] o_dump_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = (SKIP_X0 != 0) ? ADDR_W'(1) : '0;

  logic [1:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else if (i_abort && (state != S_IDLE)) begin
      // Abort drops the pending word; the walk is not resumed and no done pulse follows.
      state      <= S_IDLE;
      dump_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            cnt   <= FIRST_ADDR;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          dump_data  <= i_rs_data;
          dump_addr  <= cnt;
          dump_valid <= 1'b1;
          state      <= S_SEND;
        end
        S_SEND: begin
          if (i_dump_ready) begin
            dump_valid <= 1'b0;
            if (cnt == LAST_ADDR) begin
              state <= S_DONE;
            end else begin
              cnt   <= cnt + ADDR_W'(1);
              state <= S_FETCH;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_rs_addr    = cnt;
  assign o_dump_valid = dump_valid;
  assign o_dump_addr  = dump_addr;
  assign o_dump_data  = dump_data;
  assign o_busy       = (state != S_IDLE);
  assign o_done       = (state == S_DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: one instance walks from x0, one skips x0.
module tb_regfile_dump;
  localparam int unsigned NR = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort = 1'b0;
  logic ready = 1'b1;
  logic start [2];
  logic [AW-1:0] rs_addr [2];
  logic [DW-1:0] rs_data [2];
  logic [AW-1:0] d_addr [2];
  logic [DW-1:0] d_data [2];
  logic d_valid [2];
  logic busy [2];
  logic done [2];
  logic [DW-1:0] regs [NR];

  word_t expq [2][$];
  logic  pending [2];
  logic  held [2];
  word_t hold_w [2];
  int    done_cyc [2];
  int    done_cnt [2];
  int    start_cyc [2];
  int    cyc = 0;
  int unsigned n_pass = 0;
  int unsigned n_chk = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    regfile_dump #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SKIP_X0(g)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_start(start[g]), .i_abort(abort),
      .o_rs_addr(rs_addr[g]), .i_rs_data(rs_data[g]),
      .o_dump_valid(d_valid[g]), .i_dump_ready(ready),
      .o_dump_addr(d_addr[g]), .o_dump_data(d_data[g]),
      .o_busy(busy[g]), .o_done(done[g])
    );
    assign rs_data[g] = regs[rs_addr[g]];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chk_zero(input int u, input string nm);
    chk({nm, "_rs_addr"}, 64'(rs_addr[u]), 64'd0);
    chk({nm, "_valid"},   64'(d_valid[u]), 64'd0);
    chk({nm, "_addr"},    64'(d_addr[u]),  64'd0);
    chk({nm, "_data"},    64'(d_data[u]),  64'd0);
    chk({nm, "_busy"},    64'(busy[u]),    64'd0);
    chk({nm, "_done"},    64'(done[u]),    64'd0);
  endtask

  // Monitor: pops the scoreboard on each handshake, checks hold stability and done pulses.
  always @(negedge clk) begin
    if (rst) begin
      held[0] = 1'b0;
      held[1] = 1'b0;
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (d_valid[u]) begin
          if (held[u]) chk("hold_stable", {d_addr[u], d_data[u]}, hold_w[u]);
          if (ready) begin
            if (expq[u].size() == 0) begin
              chk("extra_word_addr", 64'(d_addr[u]), 64'hFFFF);
            end else begin
              word_t w;
              w = expq[u].pop_front();
              chk("word_addr", 64'(d_addr[u]), 64'(w.a));
              chk("word_data", 64'(d_data[u]), 64'(w.d));
            end
            held[u] = 1'b0;
          end else begin
            held[u]   = 1'b1;
            hold_w[u] = {d_addr[u], d_data[u]};
          end
        end else begin
          held[u] = 1'b0;
        end
        if (done[u]) begin
          chk("done_expected", {63'd0, pending[u]}, 64'd1);
          chk("done_queue_empty", 64'(expq[u].size()), 64'd0);
          pending[u]  = 1'b0;
          done_cyc[u] = cyc;
          done_cnt[u]++;
        end
      end
    end
  end

  task automatic start_dump(input int u);
    for (int a = u; a < int'(NR); a++) expq[u].push_back({AW'(a), regs[a]});
    pending[u]   = 1'b1;
    start_cyc[u] = cyc;
    start[u]     = 1'b1;
    @(posedge clk); #1;
    start[u] = 1'b0;
  endtask

  // mode: 0 plain, 3 backpressure, 4 abort, 5 restart+reset, 6 live write, 7 random ready
  task automatic run(input int u, input int mode);
    int i;
    int stall = 0;
    bit fired = 1'b0;
    start_dump(u);
    for (i = 0; i < 400 && (busy[u] || expq[u].size() != 0); i++) begin
      ready = 1'b1;
      case (mode)
        3: if (d_valid[u] && d_addr[u] == 5'd3 && stall < 5) begin ready = 1'b0; stall++; end
        4: if (d_valid[u] && d_addr[u] == 5'd10 && !fired) begin ready = 1'b0; abort = 1'b1; fired = 1'b1; end
        5: begin
          if (d_valid[u] && d_addr[u] == 5'd5 && !fired) begin start[u] = 1'b1; fired = 1'b1; end
          else if (d_valid[u] && d_addr[u] == 5'd20) begin ready = 1'b0; rst = 1'b1; end
        end
        6: if (d_valid[u] && d_addr[u] == 5'd2 && !fired) begin
          regs[7] = 32'hDEAD_BEEF;
          foreach (expq[u][j]) if (expq[u][j].a == 5'd7) expq[u][j].d = 32'hDEAD_BEEF;
          fired = 1'b1;
        end
        7: ready = 1'($urandom_range(0, 1));
        default: ;
      endcase
      @(posedge clk); #1;
      start[u] = 1'b0;
      if (abort) begin
        abort = 1'b0;
        expq[u].delete();
        pending[u] = 1'b0;
        chk("abort_valid", 64'(d_valid[u]), 64'd0);
        chk("abort_busy",  64'(busy[u]),    64'd0);
      end
      if (rst) begin
        rst = 1'b0;
        for (int v = 0; v < 2; v++) begin expq[v].delete(); pending[v] = 1'b0; end
        chk_zero(u, "midreset");
      end
    end
    chk("dump_finished", {63'd0, i < 400}, 64'd1);
    if (stall != 0) chk("bp_stall_cycles", 64'(stall), 64'd5);
    ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    start[0] = 1'b0; start[1] = 1'b0;
    pending[0] = 1'b0; pending[1] = 1'b0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    for (int k = 0; k < int'(NR); k++) regs[k] = 32'hA000_0000 + k;
    repeat (3) @(posedge clk);
    #1;
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    rst = 1'b0;
    @(posedge clk); #1;

    // Full dump, ready high: 32 words, done 2*W+1 cycles after the start cycle.
    run(0, 0);
    chk("t1_done_cycle", 64'(done_cyc[0] - start_cyc[0]), 64'd65);
    chk("t1_done_count", 64'(done_cnt[0]), 64'd1);

    run(1, 0);
    chk("t2_done_cycle", 64'(done_cyc[1] - start_cyc[1]), 64'd63);
    chk("t2_done_count", 64'(done_cnt[1]), 64'd1);

    run(0, 3);
    run(0, 4);
    run(0, 0);
    run(0, 5);
    run(0, 6);

    // Abort together with start in IDLE keeps the engine idle.
    abort = 1'b1; start[0] = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start[0] = 1'b0;
    chk("abort_start_idle_busy", 64'(busy[0]), 64'd0);
    @(posedge clk); #1;
    chk("abort_start_idle_valid", 64'(d_valid[0]), 64'd0);

    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < int'(NR); k++) regs[k] = $urandom;
      run(0, 7);
      run(1, 7);
    end

    chk("final_queue0", 64'(expq[0].size()), 64'd0);
    chk("final_queue1", 64'(expq[1].size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
